// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and counter width shared by the VGA sync path.
package vga_timing_pkg;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP = 33;
  localparam int unsigned CNT_W = 10;
  localparam bit SYNC_POL = 1'b0;
  function automatic int unsigned total(input int unsigned a, input int unsigned fp, input int unsigned s, input int unsigned bp);
    return a + fp + s + bp;
  endfunction
  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
endpackage

// File: rtl/pix_edge_detect.sv
// pix_edge_detect: registered one-cycle strobe on each rising edge of a synchronous level.
module pix_edge_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic level_in,
  output logic tick
);
  logic level_d;
  // level_d resets high so a level already high at release is not taken as an edge
  always_ff @(posedge clk_in) begin
    if (reset) begin
      level_d <= 1'b1;
      tick <= 1'b0;
    end else begin
      level_d <= level_in;
      tick <= level_in & ~level_d;
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing, sync, active-video and coordinates advanced by the pixel strobe.
// Define VGA_FRAME_CNT_EN to add an 8-bit frame_count output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL,
  parameter int unsigned CNT_W = vga_timing_pkg::CNT_W
) (
  input  logic clk_in,
  input  logic reset,
  input  logic pix_clk,
  output logic pix_tick,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_count
`endif
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, origin;
  pix_edge_detect u_edge (
    .clk_in(clk_in),
    .reset(reset),
    .level_in(pix_clk),
    .tick(pix_tick)
  );
  always_comb begin
    h_wrap = h_cnt == H_LAST;
    origin = h_cnt == '0 && v_cnt == '0;
  end
  // outputs take the pre-increment counters, so they trail the raster by one pixel
  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      video_on <= 1'b0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
    end else if (pix_tick) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      v_cnt <= h_wrap ? (v_cnt == V_LAST ? '0 : v_cnt + 1'b1) : v_cnt;
      x <= h_cnt;
      y <= v_cnt;
      video_on <= h_cnt < H_ACT && v_cnt < V_ACT;
      hsync <= (h_cnt >= HS_LO && h_cnt <= HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync <= (v_cnt >= VS_LO && v_cnt <= VS_HI) ? SYNC_POL : ~SYNC_POL;
      frame_start <= origin;
    end else begin
      frame_start <= 1'b0;
    end
  end
`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk_in) begin
    if (reset) frame_count <= '0;
    else if (pix_tick && origin) frame_count <= frame_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized bench for vga_sync_gen on an 8x6 raster against a pixel-index model.
module tb_vga_sync_gen;
  localparam int HT = 8, VT = 6;
  logic clk_in = 0, reset = 1, pix_clk = 1;
  logic pix_tick, hsync, vsync, video_on, frame_start;
  logic [9:0] x, y;
  int vectors = 0, miscompares = 0;
  int ticks, fs_seen, ph;
  bit pending, last, lvl;
  logic [24:0] exp_v;
  always #5 clk_in = ~clk_in;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_count;
`endif
  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .pix_clk(pix_clk),
    .pix_tick(pix_tick),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .x(x),
    .y(y),
    .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );
  function automatic logic [24:0] obs();
    return {pix_tick, hsync, vsync, video_on, frame_start, x, y};
  endfunction
  // Expected outputs come from the index of the pixel being shown: p-th tick shows pixel p.
  function automatic logic [24:0] pixel(input int p, input bit t);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return {t, !(h == 5 || h == 6), !(v == 4), h < 4 && v < 3, h == 0 && v == 0, 10'(h), 10'(v)};
  endfunction
  task automatic cyc(input bit l, input bit r);
    bit fs;
    fs = 0;
    pix_clk = l;
    reset = r;
    @(posedge clk_in);
    #1;
    vectors++;
    if (r) begin
      ticks = 0;
      pending = 0;
      last = 1;
      fs_seen = 0;
      exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0};
      return;
    end
    if (pending) begin
      exp_v = pixel(ticks, 0);
      fs = exp_v[20];
      fs_seen += int'(fs);
      ticks++;
    end
    pending = l && !last;
    last = l;
    exp_v[24] = pending;
    exp_v[20] = fs;
  endtask
  task automatic div_cycle(input int half);
    cyc(lvl, 0);
    if (++ph >= half) begin
      ph = 0;
      lvl = ~lvl;
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_hold got=%h want=%h", obs(), exp_v); end
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_no_tick got=%h want=%h", obs(), exp_v); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(i >= 2, 0);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_first_edge got=%h want=%h", obs(), exp_v); end
    end
    lvl = 1;
    ph = 2;
  endtask
  task automatic test_raster;
    int last_tick, t0;
    last_tick = -1;
    for (int i = 0; i < 2 * HT * VT * 8; i++) begin
      div_cycle(4);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL raster c=%0d got=%h want=%h", i, obs(), exp_v); end
      if (pix_tick === 1'b1) begin
        if (last_tick >= 0 && i - last_tick != 8) begin miscompares++; $display("FAIL tick_spacing got=%0d want=8", i - last_tick); end
        last_tick = i;
      end
      if (frame_start === 1'b1) begin
        if (ticks % (HT * VT) != 1) begin miscompares++; $display("FAIL frame_period ticks=%0d", ticks); end
      end
    end
  endtask
  task automatic test_stall;
    int i;
    for (i = 0; i < 200 && !(pending == 0 && ticks % HT == 4); i++) begin
      div_cycle(4);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL stall_seek got=%h want=%h", obs(), exp_v); end
    end
    if (x !== 10'd3) begin miscompares++; $display("FAIL stall_at_x got=%0d want=3", x); end
    for (int k = 0; k < 100; k++) begin
      cyc(lvl, 0);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL stall_frozen got=%h want=%h", obs(), exp_v); end
    end
    for (i = 0; i < 50 && x == 10'd3; i++) begin
      div_cycle(4);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL stall_resume got=%h want=%h", obs(), exp_v); end
    end
    if (x !== 10'd4) begin miscompares++; $display("FAIL stall_next_x got=%0d want=4", x); end
  endtask
  task automatic test_reset_mid;
    int i;
    for (i = 0; i < 1000 && !(x == 10'd6 && y == 10'd2); i++) begin
      div_cycle(4);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL mid_seek got=%h want=%h", obs(), exp_v); end
    end
    if (x !== 10'd6 || y !== 10'd2) begin miscompares++; $display("FAIL mid_seek_timeout x=%0d y=%0d want 6,2", x, y); end
    cyc(lvl, 1);
    if (obs() !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0}) begin miscompares++; $display("FAIL mid_reset got=%h want=%h", obs(), exp_v); end
    for (i = 0; i < 100 && ticks == 0; i++) begin
      div_cycle(4);
      if (obs() !== exp_v) begin miscompares++; $display("FAIL mid_restart got=%h want=%h", obs(), exp_v); end
    end
    if ({frame_start, x, y} !== {1'b1, 20'd0}) begin miscompares++; $display("FAIL mid_first_pixel got fs=%b x=%0d y=%0d want 1,0,0", frame_start, x, y); end
  endtask
  task automatic test_random;
    int half;
    for (int seg = 0; seg < 300; seg++) begin
      half = $urandom_range(1, 6);
      for (int k = $urandom_range(2, 30); k > 0; k--) begin
        if ($urandom_range(0, 9) == 0) cyc(lvl, 0);
        else div_cycle(half);
        if (obs() !== exp_v) begin miscompares++; $display("FAIL random seg=%0d got=%h want=%h", seg, obs(), exp_v); end
      end
    end
  endtask
`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_count;
    int i;
    cyc(lvl, 1);
    if (frame_count !== 8'd0) begin miscompares++; $display("FAIL fc_reset got=%0d want=0", frame_count); end
    for (i = 0; i < 40000 && fs_seen < 257; i++) begin
      div_cycle(1);
      if (frame_count !== 8'(fs_seen)) begin miscompares++; $display("FAIL fc_track got=%0d want=%0d", frame_count, 8'(fs_seen)); end
    end
    if (frame_count !== 8'd1 || fs_seen != 257) begin miscompares++; $display("FAIL fc_wrap got=%0d frames=%0d want=1 after 257", frame_count, fs_seen); end
  endtask
`endif
  initial begin
    test_reset;
    test_raster;
    test_stall;
    test_reset_mid;
    test_random;
`ifdef VGA_FRAME_CNT_EN
    test_frame_count;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the divided pixel clock from clk_divider and produces VGA horizontal/vertical timing, the active-video flag and pixel coordinates for the pixel-colour stage.
- Runs entirely in the clk_in domain.
- Detects rising edges of the divided clock and turns them into a one-cycle pixel strobe.
- All counters and outputs advance only on that strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CNT_W, 10, width of counters and x/y outputs

Ports:
- clk_in  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_clk  input  1  divided pixel clock (clk_out of clk_divider); level signal, synchronous to clk_in
- pix_tick  output  1  one-clk_in-cycle strobe per pixel
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while the output coordinate is inside the active area
- x  output  CNT_W  horizontal position of the current output pixel
- y  output  CNT_W  vertical position of the current output pixel
- frame_start  output  1  one-cycle pulse when outputs present pixel (0,0)

Behaviour:
- Clocking and reset: one clock, clk_in. reset is synchronous and active-high; all registers take their reset values on the clk_in edge where reset=1.
- Reset values:
  - pix_clk_d=1, which suppresses a spurious tick if pix_clk is high at reset release.
  - h_cnt=0, v_cnt=0, pix_tick=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - video_on=0, x=0, y=0, frame_start=0.
- Tick generation:
  - pix_clk_d <= pix_clk every cycle.
  - pix_tick is registered: 1 in the cycle after a sample with pix_clk=1 and pix_clk_d=0, otherwise 0.
  - With clk_divider toggling every 4 cycles, pix_tick fires once every 8 clk_in cycles.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
  - On pix_tick, h_cnt increments. At h_cnt=H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when it is at V_TOTAL-1 and h_cnt wraps.
  - Without pix_tick, counters hold. A stalled pix_clk freezes the raster with no error.
- Outputs:
  - Registered on pix_tick from the pre-increment counter values, giving one pixel of latency.
  - x=h_cnt, y=v_cnt.
  - video_on = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hsync = SYNC_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~SYNC_POL.
  - vsync follows the same rule on v_cnt with the V parameters.
  - frame_start=1 for exactly the cycle in which outputs update to (0,0); otherwise 0.
  - Outputs hold between ticks.
- First tick after reset: outputs show (0,0) with video_on=1 and frame_start=1; counters move to (1,0).
- Reset mid-frame: next cycle all registers are at reset values. The raster restarts at (0,0) on the next tick.
- Width rule: CNT_W must hold H_TOTAL-1 and V_TOTAL-1. All comparisons are unsigned at CNT_W.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count [7:0], reset 0.
  - Increments in the same cycle frame_start asserts; wraps 255->0.
- Undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 timing constants (H/V active, porches, sync widths, totals);
  - CNT_W;
  - SYNC_POL default.
- Sub-module pix_edge_detect:
  - inputs clk_in, reset, level_in; output tick;
  - contains pix_clk_d and the registered strobe;
  - reusable for other divided-clock consumers.
- Counter and decode logic stay in vga_sync_gen.

Test Plan:
1. Reset with pix_clk=1 held, then release -> no pix_tick until pix_clk goes 0 then 1; hsync=vsync=1, video_on=0, x=y=0 throughout.
2. Drive pix_clk from clk_divider (toggle every 4 cycles), H=4/1/2/1, V=3/1/1/1 -> pix_tick every 8 clk_in cycles; x sequence 0..7 then wraps to 0 with y incrementing; hsync low only when x=5,6.
3. Same small config over 2 frames -> vsync low only for y=4; video_on high only for x<4 && y<3; frame_start pulses exactly every 48 ticks.
4. Hold pix_clk constant for 100 cycles mid-line (x=3) -> all outputs and counters frozen; resume -> next tick gives x=4.
5. Assert reset for 1 cycle at (x=6,y=2) -> next cycle outputs at reset values; first subsequent tick gives (0,0) with frame_start=1.
6. With VGA_FRAME_CNT_EN defined, run 257 frames (small config) -> frame_count reads 1 after wrap (0..255, 0, 1).
